imem_loader: RTL and testbench

- Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives a word-write port into instruction memory.
- Holds the core in reset until the image is fully loaded.
- Sits between the host/UART byte source and the write side of instruction memory, which the core fetch path reads by word index addr[10:2].

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_word_asm.sv | 43 ++++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants for the instruction memory boot loader.
// State encoding and memory geometry.
package imem_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam int IMEM_DEPTH      = 512;
  localparam int IMEM_IDX_W      = 9;
  localparam int IMEM_ADDR_SHIFT = 2;
  localparam int IMEM_CNT_W      = 16;

endpackage

// File: rtl/imem_word_asm.sv
// Little-endian byte-to-word assembler.
// word_valid_o fires with the fourth byte.
module imem_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;

  // Shift new bytes in from the top so byte 0 ends up in [7:0].
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (en_i) begin
      sh_d  = {byte_i, sh_q[23:8]};
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Byte buffer and position counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o       = {byte_i, sh_q};
  assign word_valid_o = en_i & ~clr_i & (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream in, imem word writes out.
// Keeps the core in reset until the image is loaded.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int CNT_W = IMEM_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_start,
  input  logic [7:0]  ld_byte,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic        im_we,
  output logic [31:0] im_waddr,
  output logic [31:0] im_wdata,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err,
  output logic        cpu_rst_n
);

  localparam int IDX_W = $clog2(DEPTH + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic             we_q;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             done_q, err_q, crst_q;

  logic             xfer, start_go, last_word;
  logic             wvalid;
  logic [31:0]      word;
  logic [CNT_W-1:0] hdr_cnt;

  assign ld_busy  = (state_q == S_HDR0) |
                    (state_q == S_HDR1) |
                    (state_q == S_DATA);
  assign ld_ready = ld_busy;
  assign xfer     = ld_valid & ld_ready;

  assign start_go = ld_start & ((state_q == S_IDLE) |
                                (state_q == S_DONE) |
                                (state_q == S_ERR));

  assign hdr_cnt   = CNT_W'({ld_byte, cnt_q[7:0]});
  assign last_word = wvalid &
                     (CNT_W'(widx_q) + CNT_W'(1) == cnt_q);

  imem_word_asm u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (start_go),
    .en_i         (xfer & (state_q == S_DATA)),
    .byte_i       (ld_byte),
    .word_o       (word),
    .word_valid_o (wvalid)
  );

  // Load FSM, header capture and word index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_go) begin
          state_d = S_HDR0;
          widx_d  = '0;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          cnt_d[7:0] = ld_byte;
          state_d    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          cnt_d = hdr_cnt;
          if (hdr_cnt == '0)
            state_d = S_DONE;
          else if (hdr_cnt > CNT_W'(DEPTH))
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (wvalid) begin
          widx_d = widx_q + IDX_W'(1);
          if (last_word)
            state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write port holds its last address/data between pulses.
  always_comb begin
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wvalid) begin
      waddr_d = 32'(widx_q) << IMEM_ADDR_SHIFT;
      wdata_d = word;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      we_q    <= wvalid;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
      crst_q  <= (state_d == S_DONE);
    end
  end

  assign im_we     = we_q;
  assign im_waddr  = waddr_q;
  assign im_wdata  = wdata_q;
  assign ld_done   = done_q;
  assign ld_err    = err_q;
  assign cpu_rst_n = crst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Vector table plus hand-written corner sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        im_we;
  logic [31:0] im_waddr;
  logic [31:0] im_wdata;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;
  logic        cpu_rst_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic        wdone_q[$];

  typedef struct {
    int          nb;
    logic [95:0] bytes;
    int          nw;
    logic [63:0] wd;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_start  (ld_start),
    .ld_byte   (ld_byte),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .im_we     (im_we),
    .im_waddr  (im_waddr),
    .im_wdata  (im_wdata),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .ld_err    (ld_err),
    .cpu_rst_n (cpu_rst_n)
  );

  always @(negedge clk) begin
    if (im_we) begin
      wa_q.push_back(im_waddr);
      wd_q.push_back(im_wdata);
      wdone_q.push_back(ld_done);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic clr_log();
    wa_q.delete();
    wd_q.delete();
    wdone_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    ld_start = 1'b1;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    int n;
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = b;
    n = 0;
    while (!ld_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=%0d required=<20", n);
    end
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input int gap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], gap);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    32'(im_we),     32'd0);
    chk({tag, "_waddr"}, im_waddr,       32'd0);
    chk({tag, "_wdata"}, im_wdata,       32'd0);
    chk({tag, "_done"},  32'(ld_done),   32'd0);
    chk({tag, "_err"},   32'(ld_err),    32'd0);
    chk({tag, "_crst"},  32'(cpu_rst_n), 32'd0);
    chk({tag, "_ready"}, 32'(ld_ready),  32'd0);
    chk({tag, "_busy"},  32'(ld_busy),   32'd0);
  endtask

  function automatic logic [31:0] word_of(input int i);
    return 32'h9E3779B9 * 32'(i + 1) ^ 32'(i);
  endfunction

  initial begin
    vecs[0] = '{10, 96'h0000_3000_0F93_0000_0093_0002,
                2, {32'h30000F93, 32'h00000093},
                1'b1, 1'b0};
    vecs[1] = '{2, 96'h0, 0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{2, 96'h0201, 0, 64'h0, 1'b0, 1'b1};
    vecs[3] = '{6, 96'h1234_5678_0001,
                1, {32'h0, 32'h12345678},
                1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("idle");

    // Table-driven images, each started from IDLE/DONE/ERR.
    for (int v = 0; v < 4; v++) begin
      pulse_start();
      clr_log();
      @(negedge clk);
      chk($sformatf("v%0d_busy", v), 32'(ld_busy), 32'd1);
      chk($sformatf("v%0d_ready", v), 32'(ld_ready), 32'd1);
      chk($sformatf("v%0d_clr_done", v), 32'(ld_done), 32'd0);
      chk($sformatf("v%0d_clr_err", v), 32'(ld_err), 32'd0);
      for (int i = 0; i < vecs[v].nb; i++)
        send_byte(vecs[v].bytes[8*i +: 8], 0);
      @(negedge clk);
      chk($sformatf("v%0d_done", v),
          32'(ld_done), 32'(vecs[v].done));
      chk($sformatf("v%0d_err", v),
          32'(ld_err), 32'(vecs[v].err));
      chk($sformatf("v%0d_crst", v),
          32'(cpu_rst_n), 32'(vecs[v].done));
      chk($sformatf("v%0d_ready_end", v), 32'(ld_ready), 32'd0);
      chk($sformatf("v%0d_busy_end", v), 32'(ld_busy), 32'd0);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_nwr", v),
          32'(wa_q.size()), 32'(vecs[v].nw));
      for (int j = 0; j < vecs[v].nw && j < wa_q.size(); j++) begin
        chk($sformatf("v%0d_addr%0d", v, j),
            wa_q[j], 32'(4 * j));
        chk($sformatf("v%0d_data%0d", v, j),
            wd_q[j], vecs[v].wd[32*j +: 32]);
        chk($sformatf("v%0d_wdone%0d", v, j),
            32'(wdone_q[j]), 32'(j == vecs[v].nw - 1));
      end
    end

    // Full-depth image with random valid gaps.
    pulse_start();
    clr_log();
    send_byte(8'h00, 1);
    send_byte(8'h02, 0);
    for (int k = 0; k < 512; k++)
      send_word(word_of(k), $urandom_range(0, 1));
    repeat (5) @(negedge clk);
    chk("full_nwr", 32'(wa_q.size()), 32'd512);
    chk("full_done", 32'(ld_done), 32'd1);
    chk("full_crst", 32'(cpu_rst_n), 32'd1);
    for (int k = 0; k < 512 && k < wa_q.size(); k++) begin
      chk($sformatf("full_addr%0d", k), wa_q[k], 32'(4 * k));
      chk($sformatf("full_data%0d", k), wd_q[k], word_of(k));
    end

    // Reset in the middle of a 3-word load.
    pulse_start();
    clr_log();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_word(32'hDEADBEEF, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    chk("mid_wr_before", 32'(wa_q.size()), 32'd1);
    chk("mid_wdata_before", im_wdata, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    clr_log();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'hCAFEF00D, 0);
    send_word(32'h01234567, 0);
    repeat (3) @(negedge clk);
    chk("post_nwr", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      chk("post_addr0", wa_q[0], 32'h0);
      chk("post_data0", wd_q[0], 32'hCAFEF00D);
      chk("post_addr1", wa_q[1], 32'h4);
      chk("post_data1", wd_q[1], 32'h01234567);
    end
    chk("post_done", 32'(ld_done), 32'd1);

    // ld_start in the middle of DATA must not disturb the load.
    pulse_start();
    clr_log();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    pulse_start();
    chk("ign_busy", 32'(ld_busy), 32'd1);
    send_byte(8'hDD, 0);
    send_word(32'h76543210, 1);
    repeat (3) @(negedge clk);
    chk("ign_nwr", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      chk("ign_addr0", wa_q[0], 32'h0);
      chk("ign_data0", wd_q[0], 32'hDDCCBBAA);
      chk("ign_addr1", wa_q[1], 32'h4);
      chk("ign_data1", wd_q[1], 32'h76543210);
    end
    chk("ign_done", 32'(ld_done), 32'd1);
    chk("ign_crst", 32'(cpu_rst_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
